// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  // 50 MHz system clock / 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitHigh = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..ClksPerBit-1 and wraps. With half_i set the period
// ends at the half-bit point instead, so the first tick lands mid start bit.
// sample_tick_o is a one-cycle strobe marking a sample edge.
module uart_bit_timer #(
  parameter int unsigned ClksPerBit = uart_pkg::DEFAULT_CLKS_PER_BIT,
  parameter int unsigned CntW       = $clog2(ClksPerBit)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic half_i,
  output logic sample_tick_o
);

  localparam logic [CntW-1:0] FullMax = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfMax = CntW'(ClksPerBit / 2 - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Tick on the terminal count of the selected period, then wrap to 0
  always_comb begin
    sample_tick_o = !clear_i && (cnt_q == (half_i ? HalfMax : FullMax));
    cnt_d         = cnt_q + CntW'(1);
    if (clear_i || sample_tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 8N1, LSB first, from an already-synchronized serial line.
// Good frames load rx_byte and pulse rx_valid; a low stop bit pulses frame_err
// and then waits for the line to return high before hunting for a new start.
// Optional even parity bit between data and stop when RX_PARITY_EN is defined.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       rx_sync,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW  = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 sample_tick;
  logic                 timer_clear;
  logic                 timer_half;
`ifdef RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  // Timer restarts from 0 on the edge the start bit is first seen
  assign timer_clear = (state_q == StIdle);
  assign timer_half  = (state_q == StStart);

  uart_bit_timer #(
    .ClksPerBit(CLKS_PER_BIT),
    .CntW      (CNT_W)
  ) u_bit_timer (
    .clk_i        (clk),
    .rst_ni       (RST),
    .clear_i      (timer_clear),
    .half_i       (timer_half),
    .sample_tick_o(sample_tick)
  );

  // Next-state and frame bookkeeping
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_sync) state_d = StStart;
      end
      StStart: begin
        if (sample_tick) begin
          // High at mid start bit means it was a glitch
          if (rx_sync) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            idx_d   = '0;
          end
        end
      end
      StData: begin
        if (sample_tick) begin
          shift_d[idx_q] = rx_sync;
          idx_d          = idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
`ifdef RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      StParity: begin
        if (sample_tick) begin
          par_d   = rx_sync;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (sample_tick) begin
`ifdef RX_PARITY_EN
          // Even parity: data plus parity bit must hold an even number of ones
          perr_d = (par_q != ^shift_q);
`endif
          if (rx_sync) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        // Hold off on a break so a long low line is not taken as a new start
        if (rx_sync) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      shift_q <= '0;
      byte_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign rx_byte   = byte_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != StIdle);
`ifdef RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer at 16 clocks per bit. A frame-level model
// derives expected outputs from the sample schedule T0 + 8 + 16n and is compared
// every cycle; literal checks pin key frame results. Honours RX_PARITY_EN.
module tb_uart_rx_deserializer;

  localparam int Cpb  = 16;
  localparam int Half = Cpb / 2;
`ifdef RX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif
  localparam int StopIdx = ParEn ? 10 : 9;

  logic       clk     = 1'b0;
  logic       RST     = 1'b1;
  logic       rx_sync = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state and expected outputs after each clock edge
  int         m_mode = 0;  // 0 idle, 1 in frame, 2 waiting for line high
  int         m_rel  = 0;  // edges since T0
  int         m_n    = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_par  = 1'b0;
  logic [7:0] exp_byte  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ferr  = 1'b0;
  logic       exp_perr  = 1'b0;
  logic       exp_busy  = 1'b0;

  uart_rx_deserializer #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .rx_sync   (rx_sync),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, got, want);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic f, input logic p,
                            input logic b, input logic [7:0] by);
    check_val({tag, "_valid"}, {7'b0, rx_valid}, {7'b0, v});
    check_val({tag, "_ferr"}, {7'b0, frame_err}, {7'b0, f});
    check_val({tag, "_perr"}, {7'b0, parity_err}, {7'b0, p});
    check_val({tag, "_busy"}, {7'b0, busy}, {7'b0, b});
    check_val({tag, "_byte"}, rx_byte, by);
  endtask

  // Frame-level model: sample n lands exactly Half + n*Cpb edges after T0
  initial begin
    forever begin
      @(posedge clk or negedge RST);
      if (!RST) begin
        m_mode = 0; m_rel = 0; m_data = 8'h00; m_par = 1'b0;
        exp_byte = 8'h00; exp_valid = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0;
        exp_busy = 1'b0;
      end else begin
        exp_valid = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0;
        if (m_mode == 0) begin
          if (!rx_sync) begin m_mode = 1; m_rel = 0; end
        end else if (m_mode == 2) begin
          if (rx_sync) m_mode = 0;
        end else begin
          m_rel++;
          if (m_rel >= Half && (m_rel - Half) % Cpb == 0) begin
            m_n = (m_rel - Half) / Cpb;
            if (m_n == 0) begin
              if (rx_sync) m_mode = 0;
            end else if (m_n <= 8) begin
              m_data[m_n-1] = rx_sync;
            end else if (m_n < StopIdx) begin
              m_par = rx_sync;
            end else begin
              exp_perr = ParEn && (m_par != ^m_data);
              if (rx_sync) begin
                exp_byte = m_data; exp_valid = 1'b1; m_mode = 0;
              end else begin
                exp_ferr = 1'b1; m_mode = 2;
              end
            end
          end
        end
        exp_busy = (m_mode != 0);
      end
    end
  end

  // Every-cycle comparison, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      #1;
      check_val("cmp_rx_valid", {7'b0, rx_valid}, {7'b0, exp_valid});
      check_val("cmp_frame_err", {7'b0, frame_err}, {7'b0, exp_ferr});
      check_val("cmp_parity_err", {7'b0, parity_err}, {7'b0, exp_perr});
      check_val("cmp_busy", {7'b0, busy}, {7'b0, exp_busy});
      check_val("cmp_rx_byte", rx_byte, exp_byte);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic send_bits(input logic v, input int n);
    rx_sync = v;
    repeat (n) @(negedge clk);
  endtask

  // Start, 8 data LSB first, optional parity, stop held stop_len cycles.
  // With stop_len = Half+1 it returns just after the stop sample edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_bad,
                            input int stop_len);
    send_bits(1'b0, Cpb);
    for (int i = 0; i < 8; i++) send_bits(d[i], Cpb);
    if (ParEn) send_bits((^d) ^ par_bad, Cpb);
    send_bits(stop_v, stop_len);
  endtask

  initial begin
    logic [7:0] rd;
    #1 RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rx_sync = i[0];
    end
    #1; expect_out("reset_hold", 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    RST = 1'b1; rx_sync = 1'b1;
    send_bits(1'b1, 100);
    #1; expect_out("idle_100", 0, 0, 0, 0, 8'h00);

    // Good byte
    send_frame(8'hA5, 1'b1, 1'b0, Half + 1);
    #1; expect_out("a5_done", 1, 0, 0, 0, 8'hA5);
    @(negedge clk);
    #1; expect_out("a5_one_pulse", 0, 0, 0, 0, 8'hA5);
    send_bits(1'b1, 20);

    // Start-bit glitch
    send_bits(1'b0, 4);
    #1; expect_out("glitch_busy", 0, 0, 0, 1, 8'hA5);
    send_bits(1'b1, 5);
    #1; expect_out("glitch_idle", 0, 0, 0, 0, 8'hA5);
    send_bits(1'b1, 20);

    // Framing error then a held-low line
    send_frame(8'h3C, 1'b0, 1'b0, Half + 1);
    #1; expect_out("ferr_pulse", 0, 1, 0, 1, 8'hA5);
    send_bits(1'b0, 40);
    #1; expect_out("ferr_wait_low", 0, 0, 0, 1, 8'hA5);
    send_bits(1'b1, 20);
    #1; expect_out("ferr_recover", 0, 0, 0, 0, 8'hA5);
    send_frame(8'h55, 1'b1, 1'b0, Half + 1);
    #1; expect_out("after_ferr_55", 1, 0, 0, 0, 8'h55);
    send_bits(1'b1, Cpb - Half - 1);

    // Back-to-back with full-length stop bits
    send_frame(8'h00, 1'b1, 1'b0, Half + 1);
    #1; expect_out("b2b_00", 1, 0, 0, 0, 8'h00);
    send_bits(1'b1, Cpb - Half - 1);
    send_frame(8'hFF, 1'b1, 1'b0, Half + 1);
    #1; expect_out("b2b_ff", 1, 0, 0, 0, 8'hFF);
    // Next start the cycle right after the stop sample
    send_frame(8'h5A, 1'b1, 1'b0, Half + 1);
    #1; expect_out("fast_5a", 1, 0, 0, 0, 8'h5A);
    send_bits(1'b1, 20);

    // Reset in the middle of data bit 4
    rd = 8'hC3;
    send_bits(1'b0, Cpb);
    for (int i = 0; i < 4; i++) send_bits(rd[i], Cpb);
    send_bits(rd[4], 5);
    RST = 1'b0;
    #1; expect_out("rst_midframe", 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    RST = 1'b1; rx_sync = 1'b1;
    send_bits(1'b1, 20);
    send_frame(8'h96, 1'b1, 1'b0, Half + 1);
    #1; expect_out("after_rst_96", 1, 0, 0, 0, 8'h96);
    send_bits(1'b1, 20);

    // Wrong parity bit: flagged only when parity is built in
    send_frame(8'h07, 1'b1, 1'b1, Half + 1);
    #1; expect_out("par_07", 1, 0, ParEn, 0, 8'h07);
    send_bits(1'b1, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
